// File: rtl/lockstep_fault_ctrl_if.sv
// Signal bundle between the lockstep comparator/software side and the fault controller.
// The controller connects through the slave modport; the driving environment uses master.
interface lockstep_fault_ctrl_if;
    logic        mismatch_in;
    logic        clear_fault;
    logic        core_reset_req;
    logic        fault_fatal;
    logic        busy;
    logic [2:0]  state_out;
    logic [3:0]  retry_count;
    logic [15:0] err_count;

    modport master (
        output mismatch_in, clear_fault,
        input  core_reset_req, fault_fatal, busy, state_out, retry_count, err_count
    );

    modport slave (
        input  mismatch_in, clear_fault,
        output core_reset_req, fault_fatal, busy, state_out, retry_count, err_count
    );
endinterface

// File: rtl/lockstep_fault_ctrl.sv
// Lockstep fault controller: on a core mismatch it pulses a core reset, blanks the comparator
// while the cores settle, and escalates to a latched fatal state after too many retries.
module lockstep_fault_ctrl #(
    parameter int MAX_RETRY      = 2,
    parameter int RECOVER_CYCLES = 4,
    parameter int SETTLE_CYCLES  = 3,
    parameter int CLEAN_WINDOW   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    lockstep_fault_ctrl_if.slave  bus
);
    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_DETECT  = 3'd1;
    localparam logic [2:0] ST_RECOVER = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_FATAL   = 3'd4;

    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);
    localparam logic [15:0] RECOVER_LAST = 16'(RECOVER_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CLEAN_LAST   = 16'(CLEAN_WINDOW - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] err_q, err_d;
    logic [15:0] clean_q, clean_d;
    logic [15:0] cyc_q, cyc_d;
    logic        core_reset_q;
    logic        fatal_q;
    logic        busy_q;

    // Phase counters use terminal-count compares so they never rely on wrapping.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        err_d   = err_q;
        clean_d = clean_q;
        cyc_d   = cyc_q;
        case (state_q)
            ST_RUN: begin
                if (bus.mismatch_in) begin
                    state_d = ST_DETECT;
                    clean_d = '0;
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                end else if (clean_q == CLEAN_LAST) begin
                    clean_d = '0;
                    retry_d = '0;
                end else begin
                    clean_d = clean_q + 16'd1;
                end
            end
            ST_DETECT: begin
                cyc_d = '0;
                if (retry_q == RETRY_LIMIT) begin
                    state_d = ST_FATAL;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (cyc_q == RECOVER_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            ST_SETTLE: begin
                if (cyc_q == SETTLE_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            ST_FATAL: begin
                if (bus.clear_fault) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                    clean_d = '0;
                end
            end
            default: begin
                state_d = ST_FATAL;
                cyc_d   = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            retry_q      <= '0;
            err_q        <= '0;
            clean_q      <= '0;
            cyc_q        <= '0;
            core_reset_q <= 1'b0;
            fatal_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            err_q        <= err_d;
            clean_q      <= clean_d;
            cyc_q        <= cyc_d;
            core_reset_q <= (state_d == ST_RECOVER) || (state_d == ST_FATAL);
            fatal_q      <= (state_d == ST_FATAL);
            busy_q       <= (state_d != ST_RUN);
        end
    end

    assign bus.core_reset_req = core_reset_q;
    assign bus.fault_fatal    = fatal_q;
    assign bus.busy           = busy_q;
    assign bus.state_out      = state_q;
    assign bus.retry_count    = retry_q;
    assign bus.err_count      = err_q;
endmodule

// File: tb/tb_lockstep_fault_ctrl.sv
// Directed bench for lockstep_fault_ctrl with default parameters; expected values are
// worked out by hand from the recovery timeline (1 DETECT, 4 RECOVER, 3 SETTLE cycles).
module tb_lockstep_fault_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    lockstep_fault_ctrl_if bus ();

    lockstep_fault_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge with the given inputs; returns on the following falling edge.
    task automatic applyStimulus(input logic mm, input logic cf);
        bus.mismatch_in = mm;
        bus.clear_fault = cf;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [2:0] st, input logic crr,
                            input logic ff, input logic bsy, input logic [3:0] rc,
                            input logic [15:0] ec);
        checkOutput({tag, ".state"}, 16'(bus.state_out), 16'(st));
        checkOutput({tag, ".core_reset_req"}, 16'(bus.core_reset_req), 16'(crr));
        checkOutput({tag, ".fault_fatal"}, 16'(bus.fault_fatal), 16'(ff));
        checkOutput({tag, ".busy"}, 16'(bus.busy), 16'(bsy));
        checkOutput({tag, ".retry_count"}, 16'(bus.retry_count), 16'(rc));
        checkOutput({tag, ".err_count"}, bus.err_count, ec);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.mismatch_in = 1'b1;
        bus.clear_fault = 1'b0;
        repeat (2) @(negedge clk);
        checkAll("reset", 3'd0, 0, 0, 0, 4'd0, 16'd0);

        // Mismatch on the very first edge after reset release, then held high throughout.
        reset = 1'b1;
        applyStimulus(1, 0);
        checkAll("first_edge_detect", 3'd1, 0, 0, 1, 4'd0, 16'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0);
            checkAll($sformatf("held_recover%0d", i), 3'd2, 1, 0, 1, 4'd1, 16'd1);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0);
            checkAll($sformatf("held_settle%0d", i), 3'd3, 0, 0, 1, 4'd1, 16'd1);
        end
        applyStimulus(1, 0);
        checkAll("held_run", 3'd0, 0, 0, 0, 4'd1, 16'd1);
        applyStimulus(1, 0);
        checkAll("held_redetect", 3'd1, 0, 0, 1, 4'd1, 16'd2);

        // Recover, then a clean window returns retry_count to zero on the 16th clean cycle.
        for (int i = 0; i < 8; i++) applyStimulus(0, 0);
        checkAll("second_recovery_run", 3'd0, 0, 0, 0, 4'd2, 16'd2);
        for (int i = 0; i < 15; i++) applyStimulus(0, 0);
        checkOutput("clean15.retry_count", 16'(bus.retry_count), 16'd2);
        applyStimulus(0, 0);
        checkOutput("clean16.retry_count", 16'(bus.retry_count), 16'd0);
        applyStimulus(1, 0);
        checkAll("post_clean_detect", 3'd1, 0, 0, 1, 4'd0, 16'd3);
        applyStimulus(0, 0);
        checkAll("post_clean_recover", 3'd2, 1, 0, 1, 4'd1, 16'd3);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0);
        checkAll("post_clean_run", 3'd0, 0, 0, 0, 4'd1, 16'd3);

        applyStimulus(0, 1);
        checkAll("clear_in_run", 3'd0, 0, 0, 0, 4'd1, 16'd3);

        // Two more isolated mismatches without a clean window escalate to FATAL.
        applyStimulus(1, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0);
        checkAll("iso_run", 3'd0, 0, 0, 0, 4'd2, 16'd4);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0);
        applyStimulus(1, 0);
        checkAll("iso_detect", 3'd1, 0, 0, 1, 4'd2, 16'd5);
        applyStimulus(0, 0);
        checkAll("fatal", 3'd4, 1, 1, 1, 4'd2, 16'd5);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        checkAll("fatal_ignores_mm", 3'd4, 1, 1, 1, 4'd2, 16'd5);
        applyStimulus(0, 1);
        checkAll("fatal_clear", 3'd0, 0, 0, 0, 4'd0, 16'd5);

        // No blanking after leaving FATAL: a mismatch on the next edge is counted.
        applyStimulus(1, 0);
        checkAll("after_clear_detect", 3'd1, 0, 0, 1, 4'd0, 16'd6);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkAll("recover_cycle2", 3'd2, 1, 0, 1, 4'd1, 16'd6);

        // Asynchronous reset in the middle of the low clock phase, no edge in between.
        #2 reset = 1'b0;
        #1 checkAll("async_reset", 3'd0, 0, 0, 0, 4'd0, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 0);
        checkAll("after_reset_run", 3'd0, 0, 0, 0, 4'd0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
